// File: rtl/alp_dp_pkg.sv
// Shared select encodings, shift-engine state type and direction codes for the ALP Q/D datapath.
package alp_dp_pkg;

    // A select, one-hot {PAD,DREG,MBUS,RBUS}
    localparam logic [3:0] ALP_AMUX_NONE = 4'b0000;
    localparam logic [3:0] ALP_AMUX_RBUS = 4'b0001;
    localparam logic [3:0] ALP_AMUX_MBUS = 4'b0010;
    localparam logic [3:0] ALP_AMUX_DREG = 4'b0100;
    localparam logic [3:0] ALP_AMUX_PAD  = 4'b1000;

    // B select, one-hot {SMUX,QREG,RBUS}
    localparam logic [2:0] ALP_BMUX_NONE = 3'b000;
    localparam logic [2:0] ALP_BMUX_RBUS = 3'b001;
    localparam logic [2:0] ALP_BMUX_QREG = 3'b010;
    localparam logic [2:0] ALP_BMUX_SMUX = 3'b100;

    // Q select, one-hot {AMUX,SHR,SHL,WMUX}
    localparam logic [3:0] ALP_QMUX_NONE = 4'b0000;
    localparam logic [3:0] ALP_QMUX_WMUX = 4'b0001;
    localparam logic [3:0] ALP_QMUX_SHL  = 4'b0010;
    localparam logic [3:0] ALP_QMUX_SHR  = 4'b0100;
    localparam logic [3:0] ALP_QMUX_AMUX = 4'b1000;

    typedef enum logic [1:0] {
        QS_IDLE  = 2'd0,
        QS_SHIFT = 2'd1,
        QS_DONE  = 2'd2
    } qs_state_t;

    localparam logic QS_LEFT  = 1'b1;
    localparam logic QS_RIGHT = 1'b0;

endpackage

// File: rtl/alp_qshift_fsm.sv
// Multi-step Q shift sequencer: counts N single-bit steps, then pulses done for one cycle.
// All outputs are registered; shift/dir tell the top level to step Q on the next falling edge.
module alp_qshift_fsm
    import alp_dp_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             qdck_l,
    input  logic             reset_h,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_shift,
    output logic             o_dir
);

    qs_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_shift;
    logic             r_dir;

    always_ff @(negedge qdck_l or posedge reset_h) begin
        if (reset_h) begin
            r_state <= QS_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_shift <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                QS_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_cnt != '0) begin
                            r_state <= QS_SHIFT;
                            r_cnt   <= i_cnt;
                            r_dir   <= i_dir;
                            r_shift <= 1'b1;
                        end else begin
                            r_state <= QS_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                QS_SHIFT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // The edge that sees cnt==1 performs the final step
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= QS_DONE;
                        r_shift <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                QS_DONE: begin
                    r_state <= QS_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= QS_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_shift <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_shift = r_shift;
    assign o_dir   = r_dir;

endmodule

// File: rtl/alp_qd_seq_dp.sv
// ALP non-ALU datapath: input registers, A/B operand muxes, funnel shifter, Q/D registers.
// Q can be stepped autonomously by alp_qshift_fsm; Q loads are locked out while it is busy.
module alp_qd_seq_dp
    import alp_dp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHF_W = 2,
    parameter int CNT_W = 6
) (
    input  logic                        qdck_l,
    input  logic                        reset_h,
    input  logic                        in_en_h,
    input  logic [WIDTH-1:0]            mbus_l,
    input  logic [WIDTH-1:0]            rbus_l,
    input  logic                        extdata_l,
    input  logic [WIDTH+2**SHF_W-2:0]   sbus_l,
    input  logic [SHF_W-1:0]            shf_h,
    input  logic [3:0]                  amux_sel_h,
    input  logic [2:0]                  bmux_sel_h,
    input  logic [3:0]                  qmux_sel_h,
    input  logic                        qreg_en_h,
    input  logic                        dreg_en_h,
    input  logic [WIDTH-1:0]            wmux_l,
    output logic [WIDTH-1:0]            amux_h,
    output logic [WIDTH-1:0]            bmux_h,
    output logic [WIDTH-1:0]            qreg_h,
    input  logic                        qs_start_h,
    input  logic                        qs_dir_h,
    input  logic [CNT_W-1:0]            qs_cnt_h,
    output logic                        qs_busy_h,
    output logic                        qs_done_h,
    output logic                        q_sio_lsb_oe_h,
    output logic                        q_sio_lsb_out_h,
    input  logic                        q_sio_lsb_in_h,
    output logic                        q_sio_msb_oe_h,
    output logic                        q_sio_msb_out_h,
    input  logic                        q_sio_msb_in_h
);

    logic [WIDTH-1:0] r_mreg;
    logic [WIDTH-1:0] r_rreg;
    logic             r_ext;
    logic [WIDTH-1:0] r_qreg;
    logic [WIDTH-1:0] r_dreg;

    logic [WIDTH-1:0] w_smux;
    logic [WIDTH-1:0] w_amux;
    logic [WIDTH-1:0] w_bmux;
    logic [WIDTH-1:0] w_qmux;
    logic             w_busy;
    logic             w_shift;
    logic             w_dir;
    logic             w_qload;

    alp_qshift_fsm #(.CNT_W(CNT_W)) u_qshift (
        .qdck_l  (qdck_l),
        .reset_h (reset_h),
        .i_start (qs_start_h),
        .i_dir   (qs_dir_h),
        .i_cnt   (qs_cnt_h),
        .o_busy  (w_busy),
        .o_done  (qs_done_h),
        .o_shift (w_shift),
        .o_dir   (w_dir)
    );

    assign w_smux = ~sbus_l[shf_h +: WIDTH];

    always_comb begin
        w_amux = '0;
        case (amux_sel_h)
            ALP_AMUX_RBUS: w_amux = r_rreg;
            ALP_AMUX_MBUS: w_amux = r_mreg;
            ALP_AMUX_DREG: w_amux = r_dreg;
            ALP_AMUX_PAD:  w_amux = {WIDTH{r_ext}};
            default:       w_amux = '0;
        endcase
    end

    always_comb begin
        w_bmux = '0;
        case (bmux_sel_h)
            ALP_BMUX_RBUS: w_bmux = r_rreg;
            ALP_BMUX_QREG: w_bmux = r_qreg;
            ALP_BMUX_SMUX: w_bmux = w_smux;
            default:       w_bmux = '0;
        endcase
    end

    always_comb begin
        w_qmux = '1;
        case (qmux_sel_h)
            ALP_QMUX_WMUX: w_qmux = ~wmux_l;
            ALP_QMUX_SHL:  w_qmux = {r_qreg[WIDTH-2:0], q_sio_lsb_in_h};
            ALP_QMUX_SHR:  w_qmux = {q_sio_msb_in_h, r_qreg[WIDTH-1:1]};
            ALP_QMUX_AMUX: w_qmux = w_amux;
            default:       w_qmux = '1;
        endcase
    end

    // A start in IDLE takes precedence over a same-cycle Q load
    assign w_qload = qreg_en_h & ~w_busy & ~qs_start_h;

    always_ff @(negedge qdck_l or posedge reset_h) begin
        if (reset_h) begin
            r_mreg <= '0;
            r_rreg <= '0;
            r_ext  <= 1'b0;
            r_qreg <= '0;
            r_dreg <= '0;
        end else begin
            if (in_en_h) begin
                r_mreg <= ~mbus_l;
                r_rreg <= ~rbus_l;
                r_ext  <= ~extdata_l;
            end
            if (w_shift) begin
                if (w_dir == QS_LEFT)
                    r_qreg <= {r_qreg[WIDTH-2:0], q_sio_lsb_in_h};
                else
                    r_qreg <= {q_sio_msb_in_h, r_qreg[WIDTH-1:1]};
            end else if (w_qload) begin
                r_qreg <= w_qmux;
            end
            if (dreg_en_h)
                r_dreg <= ~wmux_l;
        end
    end

    assign amux_h          = w_amux;
    assign bmux_h          = w_bmux;
    assign qreg_h          = r_qreg;
    assign qs_busy_h       = w_busy;
    assign q_sio_lsb_out_h = r_qreg[0];
    assign q_sio_msb_out_h = r_qreg[WIDTH-1];
    assign q_sio_lsb_oe_h  = ((qmux_sel_h == ALP_QMUX_SHR) & qreg_en_h) | (w_shift & (w_dir == QS_RIGHT));
    assign q_sio_msb_oe_h  = ((qmux_sel_h == ALP_QMUX_SHL) & qreg_en_h) | (w_shift & (w_dir == QS_LEFT));

endmodule

// File: tb/tb_alp_qd_seq_dp.sv
// Directed self-checking bench for alp_qd_seq_dp (WIDTH=32, SHF_W=2, CNT_W=6).
module tb_alp_qd_seq_dp;
    import alp_dp_pkg::*;

    localparam int W  = 32;
    localparam int SW = 35;

    logic          qdck_l = 1'b1;
    logic          reset_h;
    logic          in_en_h;
    logic [W-1:0]  mbus_l, rbus_l, wmux_l;
    logic          extdata_l;
    logic [SW-1:0] sbus_l;
    logic [1:0]    shf_h;
    logic [3:0]    amux_sel_h, qmux_sel_h;
    logic [2:0]    bmux_sel_h;
    logic          qreg_en_h, dreg_en_h;
    logic [W-1:0]  amux_h, bmux_h, qreg_h;
    logic          qs_start_h, qs_dir_h;
    logic [5:0]    qs_cnt_h;
    logic          qs_busy_h, qs_done_h;
    logic          q_sio_lsb_oe_h, q_sio_lsb_out_h, q_sio_lsb_in_h;
    logic          q_sio_msb_oe_h, q_sio_msb_out_h, q_sio_msb_in_h;

    int n_cmp = 0;
    int n_err = 0;
    int n_done;

    logic [31:0] smux_exp [4] = '{32'hFFFF_0001, 32'hFFFF_8000, 32'hFFFF_C000, 32'hFFFF_E000};

    alp_qd_seq_dp #(.WIDTH(32), .SHF_W(2), .CNT_W(6)) dut (
        .qdck_l(qdck_l), .reset_h(reset_h), .in_en_h(in_en_h),
        .mbus_l(mbus_l), .rbus_l(rbus_l), .extdata_l(extdata_l),
        .sbus_l(sbus_l), .shf_h(shf_h),
        .amux_sel_h(amux_sel_h), .bmux_sel_h(bmux_sel_h), .qmux_sel_h(qmux_sel_h),
        .qreg_en_h(qreg_en_h), .dreg_en_h(dreg_en_h), .wmux_l(wmux_l),
        .amux_h(amux_h), .bmux_h(bmux_h), .qreg_h(qreg_h),
        .qs_start_h(qs_start_h), .qs_dir_h(qs_dir_h), .qs_cnt_h(qs_cnt_h),
        .qs_busy_h(qs_busy_h), .qs_done_h(qs_done_h),
        .q_sio_lsb_oe_h(q_sio_lsb_oe_h), .q_sio_lsb_out_h(q_sio_lsb_out_h),
        .q_sio_lsb_in_h(q_sio_lsb_in_h),
        .q_sio_msb_oe_h(q_sio_msb_oe_h), .q_sio_msb_out_h(q_sio_msb_out_h),
        .q_sio_msb_in_h(q_sio_msb_in_h)
    );

    always #5 qdck_l = ~qdck_l;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one falling (active) edge, then settle just after the next rising edge
    task automatic tick();
        @(negedge qdck_l);
        @(posedge qdck_l);
        #1;
    endtask

    initial begin
        reset_h = 1'b1; in_en_h = 1'b0;
        mbus_l = '1; rbus_l = '1; wmux_l = '1; extdata_l = 1'b1;
        sbus_l = '1; shf_h = 2'd0;
        amux_sel_h = ALP_AMUX_NONE; bmux_sel_h = ALP_BMUX_NONE; qmux_sel_h = ALP_QMUX_NONE;
        qreg_en_h = 1'b0; dreg_en_h = 1'b0;
        qs_start_h = 1'b0; qs_dir_h = 1'b0; qs_cnt_h = '0;
        q_sio_lsb_in_h = 1'b1; q_sio_msb_in_h = 1'b0;
        #1;
        tick();
        check_eq("rst_amux", amux_h, 0);
        check_eq("rst_bmux", bmux_h, 0);
        check_eq("rst_qreg", qreg_h, 0);
        check_eq("rst_busy_done", {qs_busy_h, qs_done_h}, 0);
        check_eq("rst_oe", {q_sio_lsb_oe_h, q_sio_msb_oe_h}, 0);
        reset_h = 1'b0;

        // Input registers and A/B muxes
        in_en_h = 1'b1; mbus_l = ~32'h1234_5678; rbus_l = ~32'hCAFE_BABE; extdata_l = 1'b0;
        amux_sel_h = ALP_AMUX_MBUS;
        tick();
        in_en_h = 1'b0; mbus_l = '1; rbus_l = '1; extdata_l = 1'b1;
        check_eq("amux_mbus", amux_h, 32'h1234_5678);
        amux_sel_h = ALP_AMUX_RBUS; bmux_sel_h = ALP_BMUX_RBUS; #1;
        check_eq("amux_rbus", amux_h, 32'hCAFE_BABE);
        check_eq("bmux_rbus", bmux_h, 32'hCAFE_BABE);
        amux_sel_h = ALP_AMUX_PAD; #1;
        check_eq("amux_pad", amux_h, 32'hFFFF_FFFF);
        amux_sel_h = 4'b0011; bmux_sel_h = 3'b101; #1;
        check_eq("amux_illegal", amux_h, 0);
        check_eq("bmux_illegal", bmux_h, 0);

        // Asynchronous reset pulse, no clock edge needed
        amux_sel_h = ALP_AMUX_MBUS;
        reset_h = 1'b1; #2; reset_h = 1'b0; #1;
        check_eq("areset_amux", amux_h, 0);
        check_eq("areset_qreg", qreg_h, 0);

        // Funnel shifter windows
        sbus_l = ~35'h7_FFFF_0001; bmux_sel_h = ALP_BMUX_SMUX;
        for (int s = 0; s < 4; s++) begin
            shf_h = 2'(s); #1;
            check_eq($sformatf("smux_shf%0d", s), bmux_h, smux_exp[s]);
        end

        // Q loads: NONE gives all-ones, then WMUX
        tick();
        qreg_en_h = 1'b1; qmux_sel_h = ALP_QMUX_NONE;
        tick();
        check_eq("qmux_none", qreg_h, 32'hFFFF_FFFF);
        qmux_sel_h = ALP_QMUX_WMUX; wmux_l = ~32'h0000_00F0;
        tick();
        check_eq("qmux_wmux", qreg_h, 32'h0000_00F0);
        qmux_sel_h = ALP_QMUX_SHR; #1;
        check_eq("oe_shr_sel", {q_sio_lsb_oe_h, q_sio_msb_oe_h}, 2'b10);
        qreg_en_h = 1'b0; qmux_sel_h = ALP_QMUX_NONE; wmux_l = '1; #1;
        check_eq("oe_idle", {q_sio_lsb_oe_h, q_sio_msb_oe_h}, 2'b00);

        // Left shift by 4 with lsb_in=1
        qs_start_h = 1'b1; qs_dir_h = QS_LEFT; qs_cnt_h = 6'd4;
        tick();
        check_eq("sl_start_q", qreg_h, 32'h0000_00F0);
        check_eq("sl_start_st", {qs_busy_h, qs_done_h, q_sio_msb_oe_h, q_sio_lsb_oe_h}, 4'b1010);
        qs_dir_h = QS_RIGHT; qs_cnt_h = 6'd2;
        tick();
        qs_start_h = 1'b0;
        qreg_en_h = 1'b1; qmux_sel_h = ALP_QMUX_WMUX; wmux_l = ~32'hDEAD_BEEF; dreg_en_h = 1'b1;
        tick();
        qreg_en_h = 1'b0; dreg_en_h = 1'b0; wmux_l = '1; qmux_sel_h = ALP_QMUX_NONE;
        check_eq("sl_step2_q", qreg_h, 32'h0000_03C3);
        tick();
        check_eq("sl_step3_st", {qs_busy_h, qs_done_h, q_sio_msb_oe_h}, 3'b101);
        tick();
        check_eq("sl_done_st", {qs_busy_h, qs_done_h, q_sio_msb_oe_h}, 3'b110);
        check_eq("sl_done_q", qreg_h, 32'h0000_0F0F);
        tick();
        check_eq("sl_idle_st", {qs_busy_h, qs_done_h}, 2'b00);
        amux_sel_h = ALP_AMUX_DREG; #1;
        check_eq("dreg_during_shift", amux_h, 32'hDEAD_BEEF);
        check_eq("sio_out", {q_sio_msb_out_h, q_sio_lsb_out_h}, 2'b01);

        // Zero count: straight to DONE, concurrent Q load dropped
        qs_start_h = 1'b1; qs_cnt_h = 6'd0;
        qreg_en_h = 1'b1; qmux_sel_h = ALP_QMUX_WMUX; wmux_l = ~32'h0000_0055;
        tick();
        qs_start_h = 1'b0; qreg_en_h = 1'b0; qmux_sel_h = ALP_QMUX_NONE; wmux_l = '1;
        check_eq("c0_done_st", {qs_busy_h, qs_done_h}, 2'b11);
        check_eq("c0_q", qreg_h, 32'h0000_0F0F);
        tick();
        check_eq("c0_idle_st", {qs_busy_h, qs_done_h}, 2'b00);
        bmux_sel_h = ALP_BMUX_QREG; #1;
        check_eq("bmux_qreg", bmux_h, 32'h0000_0F0F);

        // Right shift by 2 with msb_in=1
        q_sio_msb_in_h = 1'b1;
        qs_start_h = 1'b1; qs_dir_h = QS_RIGHT; qs_cnt_h = 6'd2;
        tick();
        qs_start_h = 1'b0;
        check_eq("sr_oe", {q_sio_lsb_oe_h, q_sio_msb_oe_h}, 2'b10);
        tick();
        check_eq("sr_step1_q", qreg_h, 32'h8000_0787);
        tick();
        check_eq("sr_done_st", {qs_busy_h, qs_done_h}, 2'b11);
        check_eq("sr_done_q", qreg_h, 32'hC000_03C3);
        tick();

        // Reset in the middle of a 10-step shift
        qs_start_h = 1'b1; qs_dir_h = QS_LEFT; qs_cnt_h = 6'd10;
        tick();
        qs_start_h = 1'b0;
        repeat (3) tick();
        check_eq("mid_busy", qs_busy_h, 1'b1);
        reset_h = 1'b1; #1;
        check_eq("mid_rst_st", {qs_busy_h, qs_done_h}, 2'b00);
        check_eq("mid_rst_q", qreg_h, 0);
        tick();
        reset_h = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (qs_done_h) n_done++;
        end
        check_eq("mid_no_done", n_done, 0);
        check_eq("mid_idle", {qs_busy_h, q_sio_msb_oe_h}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alp_qd_seq_dp.md
Name: alp_qd_seq_dp

Overview:
- Parametrised next-generation non-ALU datapath for the ALP: registered M/R/extend inputs, A/B operand muxes, funnel shifter, Q and D registers.
- Width is generalised from one 4-bit slice to WIDTH bits.
- Adds an autonomous multi-step Q shift engine (busy/done handshake) so microcode can issue one N-bit Q shift instead of N single-bit steps.
- Sits between the M/R buses and the ALU; wmux is the ALU result return path.

Parameters:
- WIDTH, 32, datapath width in bits; must be a multiple of 4 and at least 4.
- SHF_W, 2, shifter select width; sbus is WIDTH+2**SHF_W-1 bits wide.
- CNT_W, 6, shift-count width; maximum single-command shift is 2**CNT_W-1.

Ports:
- qdck_l  in  1  clock; all state updates on the falling edge of qdck_l.
- reset_h  in  1  asynchronous reset, active-high.
- in_en_h  in  1  capture mbus_l, rbus_l and extdata_l into the input registers.
- mbus_l  in  WIDTH  M bus, active-low.
- rbus_l  in  WIDTH  R bus, active-low.
- extdata_l  in  1  sign-extend pad data, active-low.
- sbus_l  in  WIDTH+2**SHF_W-1  shifter source, active-low.
- shf_h  in  SHF_W  shifter offset.
- amux_sel_h  in  4  one-hot A select: {PAD,DREG,MBUS,RBUS}; all-zero selects NONE.
- bmux_sel_h  in  3  one-hot B select: {SMUX,QREG,RBUS}; all-zero selects NONE.
- qmux_sel_h  in  4  one-hot Q select: {AMUX,SHR,SHL,WMUX}; all-zero selects NONE.
- qreg_en_h  in  1  load Q from qmux.
- dreg_en_h  in  1  load D from ~wmux_l.
- wmux_l  in  WIDTH  ALU result, active-low.
- amux_h  out  WIDTH  A operand to ALU.
- bmux_h  out  WIDTH  B operand to ALU.
- qreg_h  out  WIDTH  Q register contents.
- qs_start_h  in  1  start an iterative Q shift.
- qs_dir_h  in  1  shift direction: 1 = left, 0 = right.
- qs_cnt_h  in  CNT_W  number of single-bit steps.
- qs_busy_h  out  1  shift engine active.
- qs_done_h  out  1  one-cycle completion pulse.
- q_sio_lsb_oe_h, q_sio_lsb_out_h  out  1  LSB shift pad drive and enable.
- q_sio_lsb_in_h  in  1  LSB shift pad input.
- q_sio_msb_oe_h, q_sio_msb_out_h  out  1  MSB shift pad drive and enable.
- q_sio_msb_in_h  in  1  MSB shift pad input.

Behaviour:
- Reset (asynchronous, active-high): input registers, Q, D and the shift counter all clear to 0; state goes to IDLE; qs_busy_h=0 and qs_done_h=0.
  - After reset amux_h=0, bmux_h=0, qreg_h=0, and all pad enables are 0.
  - Reset asserted mid-shift aborts the shift; no done pulse is produced.
- Input registers capture the inverted buses when in_en_h is high; otherwise they hold.
- smux = ~sbus_l[shf_h +: WIDTH]. This is combinational.
- A mux (combinational):
  - NONE gives 0; RBUS and MBUS give the registered bus; DREG gives D; PAD replicates extdata across all bits.
  - Any non-one-hot, non-zero select gives 0.
- B mux (combinational): NONE gives 0; otherwise RBUS, Q or smux. Illegal selects give 0.
- Q mux:
  - NONE gives all-ones; WMUX gives ~wmux_l; AMUX gives amux_h.
  - SHL gives {Q[WIDTH-2:0], q_sio_lsb_in_h}.
  - SHR gives {q_sio_msb_in_h, Q[WIDTH-1:1]}.
  - Illegal selects give all-ones.
- Q loads from qmux when qreg_en_h is high and state is IDLE.
- D loads ~wmux_l when dreg_en_h is high, in every state.
- Pads:
  - q_sio_lsb_out_h = Q[0], q_sio_msb_out_h = Q[WIDTH-1].
  - lsb_oe = (qmux SHR selected and qreg_en_h) OR (state SHIFT with dir right).
  - msb_oe = (qmux SHL selected and qreg_en_h) OR (state SHIFT with dir left).
- Shift engine FSM, states IDLE, SHIFT, DONE:
  - IDLE:
    - If qs_start_h is high and qs_cnt_h is nonzero: latch dir, set cnt to qs_cnt_h, go to SHIFT. Q is unchanged this edge.
    - If qs_start_h is high and qs_cnt_h is 0: go straight to DONE.
  - SHIFT:
    - Each edge shifts Q by one bit in the latched direction, taking the serial-in from the opposite pad input, and decrements cnt.
    - When cnt reaches 1, perform the last shift and go to DONE.
  - DONE: qs_done_h=1 for exactly one cycle, then IDLE.
  - qs_busy_h is high in SHIFT and DONE.
- Latency: N steps take N+1 edges from start to the done pulse; Q holds the final value when done is high.
- Simultaneous events:
  - qs_start_h while busy is ignored.
  - qs_start_h together with qreg_en_h in IDLE: start wins and the Q load is dropped.
  - qreg_en_h while busy is ignored.
  - dreg_en_h is never blocked.

Decomposition:
- Package alp_dp_pkg holds:
  - select one-hot constants ALP_AMUX_*, ALP_BMUX_*, ALP_QMUX_*;
  - FSM state enum qs_state_t {QS_IDLE, QS_SHIFT, QS_DONE};
  - shift direction constants QS_LEFT and QS_RIGHT.
- Sub-module alp_qshift_fsm: owns the counter, state, busy/done and shift-enable/direction outputs. The top level owns the data registers and muxes.

Test Plan:
- Reset then in_en_h with mbus_l=~32'h12345678, amux_sel=MBUS -> amux_h=32'h12345678; after reset_h pulse amux_h=0, qreg_h=0.
- sbus_l=~35'h7_FFFF_0001 style pattern, shf_h=0..3, bmux_sel=SMUX -> bmux_h equals the corresponding 32-bit window each time.
- Q=32'h0000_00F0, start dir=left cnt=4, lsb_in=1 -> busy 5 cycles, done at edge 5, Q=32'h0000_0F0F, msb_oe high during SHIFT only.
- start with cnt=0 -> done next edge, Q unchanged; start while busy -> ignored, original count completes.
- reset_h asserted mid-shift (cnt=10, after 3 steps) -> busy=0, done never pulses, Q=0.
- qreg_en_h with qmux=WMUX during SHIFT -> Q follows shift only; dreg_en_h in the same cycle -> D loads ~wmux_l.
